// File: rtl/pid_pkg.sv
// Shared widths, control state encoding and saturation helpers for the steering PID.
package pid_pkg;

    localparam int ERR_W  = 10;
    localparam int INT_W  = 16;
    localparam int DIFF_W = 7;
    localparam int SPD_W  = 12;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN
    } pid_state_t;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic [SPD_W-1:0] sat_u12(input logic signed [31:0] v);
        if (v < 32'sd0) begin
            return '0;
        end
        if (v > 32'sd4095) begin
            return 12'hFFF;
        end
        return v[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/pid_dterm.sv
// Error history shift register and saturated derivative difference against the oldest entry.
module pid_dterm
    import pid_pkg::*;
#(
    parameter int D_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [ERR_W-1:0]  sample,
    output logic signed [DIFF_W-1:0] d_diff
);

    logic signed [ERR_W-1:0] hist_reg  [D_DEPTH];
    logic signed [ERR_W-1:0] hist_next [D_DEPTH];
    logic signed [31:0]      diff_full;

    genvar gi;
    generate
        for (gi = 0; gi < D_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = sample;
            end else begin : g_tail
                assign hist_next[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    assign diff_full = 32'(sample) - 32'(hist_reg[D_DEPTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= '{default: '0};
            d_diff   <= '0;
        end else if (clear) begin
            hist_reg <= '{default: '0};
            d_diff   <= '0;
        end else if (enable) begin
            hist_reg <= hist_next;
            d_diff   <= DIFF_W'(sat_s(diff_full, DIFF_W));
        end
    end

endmodule

// File: rtl/pid_ctrl.sv
// Two-stage steering PID: saturate/integrate/differentiate, then combine and map to wheel speeds.
module pid_ctrl
    import pid_pkg::*;
#(
    parameter logic signed [5:0] P_COEF   = 6'sd4,
    parameter logic signed [5:0] D_COEF   = 6'sd6,
    parameter int                I_SHIFT  = 4,
    parameter int                D_DEPTH  = 2,
    parameter logic [11:0]       BASE_SPD = 12'h400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              err_vld,
    input  logic signed [15:0] error,
    output logic [SPD_W-1:0]  lft_spd,
    output logic [SPD_W-1:0]  rght_spd,
    output logic              pid_vld
);

    pid_state_t               state_reg;
    logic                     clear;
    logic                     accept;
    logic signed [ERR_W-1:0]  sat_err;
    logic signed [ERR_W-1:0]  err_s1_reg;
    logic signed [INT_W-1:0]  integ_reg;
    logic signed [INT_W-1:0]  integ_next;
    logic signed [DIFF_W-1:0] d_diff;
    logic                     s1_vld_reg;
    logic signed [31:0]       p_term;
    logic signed [31:0]       i_term;
    logic signed [31:0]       d_term;
    logic signed [31:0]       base_s;
    logic signed [INT_W-1:0]  pid;

    // Leaving RUN wipes every piece of state, flushing any sample still in flight.
    assign clear  = (state_reg == RUN) && !go;
    assign accept = err_vld && go;

    assign sat_err    = ERR_W'(sat_s(32'(error), ERR_W));
    assign integ_next = INT_W'(sat_s(32'(integ_reg) + 32'(sat_err), INT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= go ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg <= 1'b0;
            err_s1_reg <= '0;
            integ_reg  <= '0;
        end else if (clear) begin
            s1_vld_reg <= 1'b0;
            err_s1_reg <= '0;
            integ_reg  <= '0;
        end else begin
            s1_vld_reg <= accept;
            if (accept) begin
                err_s1_reg <= sat_err;
                integ_reg  <= integ_next;
            end
        end
    end

    pid_dterm #(
        .D_DEPTH(D_DEPTH)
    ) u_dterm (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .enable(accept),
        .sample(sat_err),
        .d_diff(d_diff)
    );

    // integ_reg already holds the post-update value while the sample sits in stage 1.
    assign p_term = 32'(err_s1_reg) * 32'(P_COEF);
    assign i_term = 32'(integ_reg >>> I_SHIFT);
    assign d_term = 32'(d_diff) * 32'(D_COEF);
    assign pid    = INT_W'(p_term + i_term + d_term);
    assign base_s = $signed(32'(BASE_SPD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else if (clear) begin
            pid_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            pid_vld <= s1_vld_reg;
            if (s1_vld_reg) begin
                lft_spd  <= sat_u12(base_s + 32'(pid));
                rght_spd <= sat_u12(base_s - 32'(pid));
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl.sv
// Bench for pid_ctrl: directed vectors, flush/reset sequences and random traffic against a reference model.
module tb_pid_ctrl;

    localparam int P_GAIN = 4;
    localparam int D_GAIN = 6;
    localparam int I_DIV  = 16;
    localparam int DEPTH  = 2;
    localparam int BASE   = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go;
    logic              err_vld;
    logic signed [15:0] error;
    logic [11:0]       lft_spd;
    logic [11:0]       rght_spd;
    logic              pid_vld;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pid_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .err_vld (err_vld),
        .error   (error),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .pid_vld (pid_vld)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int l;
        int r;
    } pend_t;

    pend_t       pend[$];
    int          hist_q[$];
    int          m_integ;
    int          cyc;
    logic        exp_vld;
    logic [11:0] exp_l;
    logic [11:0] exp_r;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    task automatic model_clear();
        m_integ = 0;
        hist_q.delete();
        for (int k = 0; k < DEPTH; k++) hist_q.push_back(0);
        pend.delete();
        exp_vld = 1'b0;
        exp_l   = '0;
        exp_r   = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
            cyc = 0;
        end else begin
            cyc++;
            exp_vld = 1'b0;
            if (!go) begin
                model_clear();
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    pend_t it;
                    it      = pend.pop_front();
                    exp_vld = 1'b1;
                    exp_l   = 12'(it.l);
                    exp_r   = 12'(it.r);
                end
                if (err_vld) begin
                    int s, d, pidv;
                    pend_t nw;
                    s       = clampi(int'(error), -512, 511);
                    m_integ = clampi(m_integ + s, -32768, 32767);
                    d       = clampi(s - hist_q[DEPTH-1], -64, 63);
                    hist_q.push_front(s);
                    void'(hist_q.pop_back());
                    pidv    = wrap16(s * P_GAIN + floor_div(m_integ, I_DIV) + d * D_GAIN);
                    nw.due  = cyc + 1;
                    nw.l    = clampi(BASE + pidv, 0, 4095);
                    nw.r    = clampi(BASE - pidv, 0, 4095);
                    pend.push_back(nw);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("mon_vld", 32'(pid_vld), 32'(exp_vld));
        chk("mon_lft", 32'(lft_spd), 32'(exp_l));
        chk("mon_rght", 32'(rght_spd), 32'(exp_r));
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int n;
        int err;
        int l;
        int r;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int e);
        err_vld = 1'b1;
        error   = 16'(e);
        tick();
        err_vld = 1'b0;
    endtask

    task automatic wait_vld(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pid_vld === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic ok;
        vecs[0] = '{n: 1,  err: 100,   l: 1808, r: 240};
        vecs[1] = '{n: 1,  err: 32767, l: 3477, r: 0};
        vecs[2] = '{n: 3,  err: -40,   l: 856,  r: 1192};
        vecs[3] = '{n: 65, err: 511,   l: 4095, r: 0};

        rst_n = 1'b0; go = 1'b0; err_vld = 1'b0; error = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_vld", 32'(pid_vld), 32'd0);
        chk("reset_lft", 32'(lft_spd), 32'd0);
        chk("reset_rght", 32'(rght_spd), 32'd0);
        tick();

        // Directed vectors, each from a freshly cleared state.
        for (int v = 0; v < 4; v++) begin
            go = 1'b0;
            tick();
            go = 1'b1;
            for (int p = 0; p < vecs[v].n; p++) begin
                send(vecs[v].err);
                if (p != vecs[v].n - 1) tick();
            end
            wait_vld(ok);
            chk($sformatf("vec%0d_vld", v), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_lft", v), 32'(lft_spd), 32'(vecs[v].l));
            chk($sformatf("vec%0d_rght", v), 32'(rght_spd), 32'(vecs[v].r));
            tick();
        end

        // go drops for one cycle right after a sample: flush.
        send(100);
        go = 1'b0;
        tick();
        go = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_vld", 32'(pid_vld), 32'd0);
        end
        chk("flush_lft", 32'(lft_spd), 32'd0);
        chk("flush_rght", 32'(rght_spd), 32'd0);
        tick();
        send(100);
        wait_vld(ok);
        chk("reflush_vld", 32'(ok), 32'd1);
        chk("reflush_lft", 32'(lft_spd), 32'd1808);
        chk("reflush_rght", 32'(rght_spd), 32'd240);
        tick();

        // Reset one cycle after a sample, then a back-to-back pair.
        send(100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_vld", 32'(pid_vld), 32'd0);
        chk("rst_lft", 32'(lft_spd), 32'd0);
        chk("rst_rght", 32'(rght_spd), 32'd0);
        tick();
        rst_n   = 1'b1;
        err_vld = 1'b1;
        error   = 16'sd100;
        tick();
        tick();
        err_vld = 1'b0;
        @(negedge clk);
        chk("pair0_vld", 32'(pid_vld), 32'd1);
        chk("pair0_lft", 32'(lft_spd), 32'd1808);
        @(negedge clk);
        chk("pair1_vld", 32'(pid_vld), 32'd1);
        chk("pair1_lft", 32'(lft_spd), 32'd1814);
        chk("pair1_rght", 32'(rght_spd), 32'd234);
        @(negedge clk);
        chk("pair_end_vld", 32'(pid_vld), 32'd0);
        tick();

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 600; c++) begin
            go      = ($urandom_range(0, 24) != 0);
            err_vld = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1)
                error = 16'($signed($urandom_range(0, 1400)) - 700);
            else
                error = 16'($urandom());
            tick();
        end
        err_vld = 1'b0;
        go      = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pid_ctrl.md
Name: pid_ctrl

Overview:
Steering PID stage directly downstream of the IR error computation block. It consumes the 16-bit signed line-position error and its one-cycle err_vld strobe. It computes proportional, integral and derivative terms and produces saturated 12-bit left/right wheel speed commands with a one-cycle pid_vld strobe for the motor PWM stage.

Parameters:
P_COEF, 4, signed proportional gain (6-bit signed, range -32..31)
D_COEF, 6, signed derivative gain (6-bit signed)
I_SHIFT, 4, arithmetic right shift applied to the integrator to form I_term
D_DEPTH, 2, number of err_vld samples back used for the derivative difference (1..8)
BASE_SPD, 12'h400, nominal forward speed added/subtracted around the PID output

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
go  input  1  run enable; low clears integrator, history and outputs
err_vld  input  1  one-cycle strobe, error valid
error  input  16  signed error from error computation stage
lft_spd  output  12  unsigned left wheel speed command
rght_spd  output  12  unsigned right wheel speed command
pid_vld  output  1  one-cycle strobe, speeds updated

Behaviour:
- Single clock clk; reset asynchronous, active-low on rst_n. Reset: lft_spd=0, rght_spd=0, pid_vld=0, integrator=0, derivative history=0, pipeline valids=0.
- Sample accepted only when err_vld && go.
- Stage 1 (clock edge of accepted err_vld):
  - sat_err = error saturated to 10-bit signed [-512,511].
  - integrator (16-bit signed) += sign-extended sat_err; on overflow clamp to 32767 / -32768, never wrap.
  - d_diff = sat_err - hist[D_DEPTH-1], saturated to 7-bit signed [-64,63].
  - hist shifts in sat_err.
  - All results registered with valid s1.
- Stage 2:
  - P_term = sat_err*P_COEF.
  - I_term = integrator_new >>> I_SHIFT (arithmetic, floors toward -inf); uses the post-update integrator.
  - D_term = d_diff*D_COEF.
  - pid = P+I+D in 16-bit signed.
  - lft_spd = sat_u12(BASE_SPD + pid); rght_spd = sat_u12(BASE_SPD - pid); sat_u12 clamps to [0,4095].
  - Registered with pid_vld=1.
- Latency: pid_vld pulses exactly 2 cycles after accepted err_vld. Outputs hold between updates.
- Fully pipelined: back-to-back err_vld on consecutive cycles gives back-to-back pid_vld.
- Control FSM states IDLE and RUN:
  - IDLE→RUN when go=1.
  - RUN→IDLE when go=0.
  - Entering IDLE, on the next edge: integrator, hist, pipeline valids and lft_spd/rght_spd all cleared to 0; pid_vld=0.
  - go falling mid-pipeline flushes; no pid_vld issued for the in-flight sample.
- err_vld while go=0: ignored, no state change.
- Reset mid-operation: all state immediately cleared; no pid_vld for in-flight samples.

Decomposition:
- Package pid_pkg holds:
  - width constants ERR_W=10, INT_W=16, DIFF_W=7, SPD_W=12.
  - typedef enum {IDLE,RUN} pid_state_t.
  - Saturation functions sat_s(width), sat_u12.
- Sub-module pid_dterm: history shift register of depth D_DEPTH plus saturated difference; same clk/rst_n/clear/enable.

Test Plan:
- Defaults, go=1 after reset, single err_vld with error=100 → pid_vld 2 cycles later; lft_spd=1808, rght_spd=240 (P=400, I=6, D=378).
- Fresh state, error=16'h7FFF → sat_err=511; lft_spd=3477, rght_spd=0 (low clamp).
- Three err_vld pulses with error=-40 → third output P=-160, I=-8, D=0, lft_spd=856, rght_spd=1192.
- 65 err_vld pulses of error=511 → integrator clamps at 32767 (not wrap); I_term=2047 on 65th and later.
- Mid-run drop go for 1 cycle one cycle after err_vld → no pid_vld; lft_spd=rght_spd=0. Next accepted error=100 reproduces the first scenario's values.
- Assert rst_n low one cycle after err_vld → pid_vld never pulses; all outputs 0; integrator 0. Consecutive-cycle err_vld pair (100, 100) after reset → two consecutive pid_vld pulses.
